// File: rtl/floor_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : floor_call_scheduler
// Purpose  : Ordered store of pending floor calls for one elevator cabin.
//            A new call is placed at the front of the queue when the cabin
//            will pass that floor on the way to the current head. Otherwise
//            it goes to the tail. Calls to floors already queued are
//            suppressed, and calls that find the queue full are dropped
//            with an overflow pulse. The head entry is the next destination
//            for the motion controller.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            call_valid/floor/dir   - call strobe, requested floor, direction
//            move_dir, actual_floor - current cabin direction and position
//            pop                    - head served, remove entry 0
//            head_floor/head_valid  - entry 0 and queue-not-empty
//            count/full             - occupancy and count==DEPTH
//            ins_flag               - 11 front, 10 tail, 01 duplicate, 00 none
//            overflow               - call dropped because queue was full
// Revision : 1.0 - initial release
// ============================================================================
module floor_call_scheduler #(
    parameter int FLOOR_W = 2,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call_valid,
    input  logic [FLOOR_W-1:0] call_floor,
    input  logic               call_dir,
    input  logic               move_dir,
    input  logic [FLOOR_W-1:0] actual_floor,
    input  logic               pop,
    output logic [FLOOR_W-1:0] head_floor,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic [1:0]         ins_flag,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [1:0]       C_INS_NONE  = 2'b00;
    localparam logic [1:0]       C_INS_DUP   = 2'b01;
    localparam logic [1:0]       C_INS_TAIL  = 2'b10;
    localparam logic [1:0]       C_INS_FRONT = 2'b11;

    logic [FLOOR_W-1:0] mem_q [DEPTH];
    logic [FLOOR_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         ins_q, ins_d;
    logic               ovf_q, ovf_d;
    logic               hv_q, full_q;

    // Queue as seen after the pop has been applied; the call is judged
    // against this view so a same-cycle pop frees a slot and removes the
    // old head from duplicate matching.
    logic [FLOOR_W-1:0] w_pop_mem [DEPTH];
    logic [CNT_W-1:0]   w_pop_cnt;
    logic               w_dup;
    logic               w_between;
    logic               w_inroute;

    always_comb begin
        w_pop_mem = mem_q;
        w_pop_cnt = count_q;
        if (pop && (count_q != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_pop_mem[i] = mem_q[i+1];
            end
            w_pop_mem[DEPTH-1] = '0;
            w_pop_cnt          = count_q - C_ONE;
        end
    end

    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < w_pop_cnt) && (w_pop_mem[i] == call_floor)) begin
                w_dup = 1'b1;
            end
        end
    end

    // Strictly between the cabin and the head, in the direction of travel.
    always_comb begin
        if (move_dir) begin
            w_between = (actual_floor < call_floor) && (call_floor < w_pop_mem[0]);
        end else begin
            w_between = (w_pop_mem[0] < call_floor) && (call_floor < actual_floor);
        end
        w_inroute = (w_pop_cnt != '0) && (call_dir == move_dir) && w_between;
    end

    always_comb begin
        mem_d   = w_pop_mem;
        count_d = w_pop_cnt;
        ins_d   = C_INS_NONE;
        ovf_d   = 1'b0;
        if (call_valid) begin
            if (w_dup) begin
                ins_d = C_INS_DUP;
            end else if (w_pop_cnt == C_DEPTH) begin
                ovf_d = 1'b1;
            end else if (w_inroute) begin
                // Not full here, so the entry shifted out of the top is unused.
                mem_d[0] = call_floor;
                for (int i = 1; i < DEPTH; i++) begin
                    mem_d[i] = w_pop_mem[i-1];
                end
                count_d = w_pop_cnt + C_ONE;
                ins_d   = C_INS_FRONT;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == w_pop_cnt) begin
                        mem_d[i] = call_floor;
                    end
                end
                count_d = w_pop_cnt + C_ONE;
                ins_d   = C_INS_TAIL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            ins_q   <= C_INS_NONE;
            ovf_q   <= 1'b0;
            hv_q    <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q <= count_d;
            ins_q   <= ins_d;
            ovf_q   <= ovf_d;
            hv_q    <= (count_d != '0);
            full_q  <= (count_d == C_DEPTH);
        end
    end

    assign head_floor = mem_q[0];
    assign head_valid = hv_q;
    assign count      = count_q;
    assign full       = full_q;
    assign ins_flag   = ins_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_floor_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_floor_call_scheduler
// Purpose  : Self-checking bench for floor_call_scheduler. A queue-level
//            model tracks the FLOOR_W=2 instance every cycle; directed
//            vectors carry hand-computed expectations. A FLOOR_W=3 instance
//            covers overflow, which cannot occur with two-bit floors because
//            a full four-entry queue already holds every floor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_floor_call_scheduler;

    localparam int FW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, call_valid, call_dir, move_dir, pop;
    logic [FW-1:0] call_floor, actual_floor;
    logic [FW-1:0] head_floor;
    logic          head_valid, full, overflow;
    logic [CW-1:0] count;
    logic [1:0]    ins_flag;

    logic          r3_reset, r3_cv, r3_cd, r3_md, r3_pop;
    logic [2:0]    r3_cf, r3_af, r3_head;
    logic          r3_hv, r3_full, r3_ovf;
    logic [CW-1:0] r3_count;
    logic [1:0]    r3_ins;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    floor_call_scheduler #(.FLOOR_W(FW), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
        .call_dir(call_dir), .move_dir(move_dir), .actual_floor(actual_floor), .pop(pop),
        .head_floor(head_floor), .head_valid(head_valid), .count(count), .full(full),
        .ins_flag(ins_flag), .overflow(overflow)
    );

    floor_call_scheduler #(.FLOOR_W(3), .DEPTH(DEPTH)) u_dut_w3 (
        .clk(clk), .reset(r3_reset), .call_valid(r3_cv), .call_floor(r3_cf),
        .call_dir(r3_cd), .move_dir(r3_md), .actual_floor(r3_af), .pop(r3_pop),
        .head_floor(r3_head), .head_valid(r3_hv), .count(r3_count), .full(r3_full),
        .ins_flag(r3_ins), .overflow(r3_ovf)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- queue-level reference model ----------------
    int mq[$];
    int exp_ins, exp_ovf;
    bit model_ready = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            exp_ins     = 0;
            exp_ovf     = 0;
            model_ready = 1'b1;
        end else begin
            int  cf, af;
            bit  dup;
            cf = int'(call_floor);
            af = int'(actual_floor);
            if (pop && mq.size() > 0) void'(mq.pop_front());
            exp_ins = 0;
            exp_ovf = 0;
            if (call_valid) begin
                dup = 1'b0;
                foreach (mq[i]) if (mq[i] == cf) dup = 1'b1;
                if (dup) exp_ins = 1;
                else if (mq.size() == DEPTH) exp_ovf = 1;
                else if (mq.size() > 0 && call_dir == move_dir &&
                         (move_dir ? (af < cf && cf < mq[0]) : (mq[0] < cf && cf < af))) begin
                    mq.push_front(cf);
                    exp_ins = 3;
                end else begin
                    mq.push_back(cf);
                    exp_ins = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("model count",      int'(count),      mq.size());
            chk("model head_valid", int'(head_valid), (mq.size() != 0) ? 1 : 0);
            chk("model full",       int'(full),       (mq.size() == DEPTH) ? 1 : 0);
            chk("model head_floor", int'(head_floor), (mq.size() != 0) ? mq[0] : 0);
            chk("model ins_flag",   int'(ins_flag),   exp_ins);
            chk("model overflow",   int'(overflow),   exp_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit cv, input int cf, input bit cd, input bit md,
                       input int af, input bit pp, input bit rs);
        reset        = rs;
        call_valid   = cv;
        call_floor   = FW'(cf);
        call_dir     = cd;
        move_dir     = md;
        actual_floor = FW'(af);
        pop          = pp;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc3(input bit cv, input int cf, input bit cd, input bit md,
                        input int af, input bit pp, input bit rs);
        r3_reset = rs;
        r3_cv    = cv;
        r3_cf    = 3'(cf);
        r3_cd    = cd;
        r3_md    = md;
        r3_af    = 3'(af);
        r3_pop   = pp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; call_valid = 1'b0; call_floor = '0; call_dir = 1'b0;
        move_dir = 1'b0; actual_floor = '0; pop = 1'b0;
        r3_reset = 1'b1; r3_cv = 1'b0; r3_cf = '0; r3_cd = 1'b0;
        r3_md = 1'b0; r3_af = '0; r3_pop = 1'b0;

        // Reset then idle
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("reset count", int'(count), 0);
        chk("reset head_valid", int'(head_valid), 0);
        chk("reset full", int'(full), 0);
        chk("reset ins_flag", int'(ins_flag), 0);
        chk("reset overflow", int'(overflow), 0);

        // Append ordering
        cyc(1, 3, 1, 1, 0, 0, 0);
        chk("append1 ins_flag", int'(ins_flag), 2);
        chk("append1 head", int'(head_floor), 3);
        cyc(1, 1, 0, 1, 0, 0, 0);
        chk("append2 ins_flag", int'(ins_flag), 2);
        chk("append2 count", int'(count), 2);
        chk("append2 head", int'(head_floor), 3);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("idle ins_flag", int'(ins_flag), 0);

        // In-route insert going up
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 3, 1, 1, 0, 0, 0);
        cyc(1, 2, 1, 1, 0, 0, 0);
        chk("inroute up ins_flag", int'(ins_flag), 3);
        chk("inroute up head", int'(head_floor), 2);
        chk("inroute up count", int'(count), 2);

        // Duplicate, then equality with actual_floor appends
        cyc(1, 3, 1, 1, 0, 0, 0);
        chk("dup ins_flag", int'(ins_flag), 1);
        chk("dup count", int'(count), 2);
        cyc(1, 0, 1, 1, 0, 0, 0);
        chk("eq actual ins_flag", int'(ins_flag), 2);
        chk("eq actual count", int'(count), 3);
        chk("eq actual head", int'(head_floor), 2);
        cyc(1, 1, 0, 1, 0, 0, 0);
        chk("fill full", int'(full), 1);
        chk("fill count", int'(count), 4);

        // Pop the head and re-call it in the same cycle: not a duplicate
        cyc(1, 2, 1, 1, 0, 1, 0);
        chk("pop+recall ins_flag", int'(ins_flag), 3);
        chk("pop+recall count", int'(count), 4);
        chk("pop+recall overflow", int'(overflow), 0);
        cyc(0, 0, 0, 1, 0, 1, 0);
        chk("pop count", int'(count), 3);
        chk("pop head", int'(head_floor), 3);
        chk("pop full", int'(full), 0);

        // Reset mid-operation overrides call and pop
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 1, 0, 0, 0);
        cyc(1, 3, 1, 1, 0, 0, 0);
        chk("q13 head", int'(head_floor), 1);
        chk("q13 count", int'(count), 2);
        cyc(1, 2, 1, 1, 0, 1, 1);
        chk("midreset count", int'(count), 0);
        chk("midreset head_valid", int'(head_valid), 0);
        chk("midreset ins_flag", int'(ins_flag), 0);

        // Pop on an empty queue is ignored
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("empty pop count", int'(count), 0);

        // In-route insert going down, and boundary equality with actual
        cyc(1, 0, 0, 0, 3, 0, 0);
        cyc(1, 2, 0, 0, 3, 0, 0);
        chk("inroute dn ins_flag", int'(ins_flag), 3);
        chk("inroute dn head", int'(head_floor), 2);
        cyc(1, 1, 0, 0, 3, 0, 0);
        chk("not between ins_flag", int'(ins_flag), 2);
        cyc(1, 3, 0, 0, 3, 0, 0);
        chk("eq actual dn ins_flag", int'(ins_flag), 2);
        chk("eq actual dn count", int'(count), 4);
        cyc(0, 0, 0, 0, 3, 0, 0);

        // Overflow on the three-bit instance
        cyc3(0, 0, 0, 0, 0, 0, 1);
        cyc3(1, 1, 0, 1, 0, 0, 0);
        cyc3(1, 2, 0, 1, 0, 0, 0);
        cyc3(1, 3, 0, 1, 0, 0, 0);
        cyc3(1, 4, 0, 1, 0, 0, 0);
        chk("w3 fill count", int'(r3_count), 4);
        chk("w3 fill full", int'(r3_full), 1);
        chk("w3 fill head", int'(r3_head), 1);
        cyc3(1, 5, 0, 1, 0, 0, 0);
        chk("w3 overflow", int'(r3_ovf), 1);
        chk("w3 overflow ins_flag", int'(r3_ins), 0);
        chk("w3 overflow count", int'(r3_count), 4);
        cyc3(1, 5, 0, 1, 0, 1, 0);
        chk("w3 pop+call overflow", int'(r3_ovf), 0);
        chk("w3 pop+call ins_flag", int'(r3_ins), 2);
        chk("w3 pop+call count", int'(r3_count), 4);
        chk("w3 pop+call head", int'(r3_head), 2);
        cyc3(0, 0, 0, 1, 0, 0, 0);
        chk("w3 idle overflow", int'(r3_ovf), 0);
        chk("w3 idle ins_flag", int'(r3_ins), 0);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
